// File: rtl/feeder_pkg.sv
// Shared definitions for the feeder dispense controller and the countdown timer:
// FSM state encoding, portion width, default cycle constants and counter helpers.
package feeder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t RUN    = 2'd1;
    localparam state_t SETTLE = 2'd2;
    localparam state_t FAULT  = 2'd3;

    localparam int PORTION_W = 3;

    localparam logic [31:0]          DEF_TIMEOUT_CYCLES  = 32'd250_000_000;
    localparam logic [31:0]          DEF_SETTLE_CYCLES   = 32'd25_000_000;
    localparam logic [31:0]          DEF_DEBOUNCE_CYCLES = 32'd500_000;
    localparam logic [PORTION_W-1:0] DEF_INIT_PORTIONS   = 3'd7;

    // True on the last cycle of a LIMIT-cycle interval; a zero limit expires at once.
    function automatic logic count_done(input logic [31:0] cnt, input logic [31:0] limit);
        return ({1'b0, cnt} + 33'd1) >= {1'b0, limit};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == '1) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/feeder_dispense_ctrl_if.sv
// Feed-request handshake and status bundle between the countdown timer (master)
// and the dispense controller (slave).
interface feeder_dispense_ctrl_if;
    import feeder_pkg::*;

    // m_req is a level the timer holds high until it sees m_ack; m_ack is a
    // one-cycle pulse; motor_on, sensor_on and portions are registered status.
    logic                 m_req;
    logic                 m_ack;
    logic                 motor_on;
    logic                 sensor_on;
    logic [PORTION_W-1:0] portions;

    modport master (output m_req, input m_ack, motor_on, sensor_on, portions);
    modport slave  (input m_req, output m_ack, motor_on, sensor_on, portions);

endinterface

// File: rtl/sensor_conditioner.sv
// Two-flop synchronizer for the raw portion sensor, with an optional debounce
// stage compiled in by FEEDER_DISPENSE_DEBOUNCE_EN.
module sensor_conditioner
    import feeder_pkg::*;
#(
    parameter logic [31:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic level_out,
    output logic rise_pulse
);

    logic sync_a;
    logic next_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_a <= 1'b0;
        else        sync_a <= raw_in;
    end

`ifdef FEEDER_DISPENSE_DEBOUNCE_EN
    logic        sync_b;
    logic [31:0] db_cnt;

    // Counts consecutive samples that disagree with the current level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_b <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync_b <= sync_a;
            if (sync_b == level_out || count_done(db_cnt, DEBOUNCE_CYCLES)) db_cnt <= '0;
            else                                                             db_cnt <= db_cnt + 32'd1;
        end
    end

    assign next_level = (sync_b != level_out && count_done(db_cnt, DEBOUNCE_CYCLES)) ? sync_b
                                                                                     : level_out;
`else
    logic unused_debounce;
    assign unused_debounce = ^DEBOUNCE_CYCLES;
    // level_out itself is the second synchronizer flop here.
    assign next_level = sync_a;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            level_out  <= next_level;
            rise_pulse <= next_level & ~level_out;
        end
    end

endmodule

// File: rtl/feeder_dispense_ctrl.sv
// Dispense controller answering the timer's feed request: runs the motor until a
// portion drop or timeout. Debounce option: FEEDER_DISPENSE_DEBOUNCE_EN.
module feeder_dispense_ctrl
    import feeder_pkg::*;
#(
    parameter logic [31:0]          TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter logic [31:0]          SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter logic [31:0]          DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [PORTION_W-1:0] INIT_PORTIONS   = DEF_INIT_PORTIONS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    feeder_dispense_ctrl_if.slave        bus,
    input  logic                         sensor_in,
    input  logic                         refill,
    input  logic                         fault_clr,
    output logic                         motor_en,
    output logic                         empty,
    output logic                         fault,
    output state_t                       state_dbg
);

    state_t               state;
    logic [31:0]          cnt;
    logic                 ack_r;
    logic [PORTION_W-1:0] portions_r;
    logic                 sens_level;
    logic                 sens_rise;

    sensor_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sensor (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (sensor_in),
        .level_out  (sens_level),
        .rise_pulse (sens_rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ack_r      <= 1'b0;
            motor_en   <= 1'b0;
            fault      <= 1'b0;
            portions_r <= INIT_PORTIONS;
        end else begin
            ack_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.m_req) begin
                        ack_r <= 1'b1;
                        if (portions_r != '0) begin
                            motor_en <= 1'b1;
                            cnt      <= '0;
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    // A sensor edge outranks a timeout landing in the same cycle.
                    if (sens_rise) begin
                        motor_en <= 1'b0;
                        if (portions_r != '0) portions_r <= portions_r - 1'b1;
                        cnt   <= '0;
                        state <= SETTLE;
                    end else if (count_done(cnt, TIMEOUT_CYCLES)) begin
                        motor_en <= 1'b0;
                        fault    <= 1'b1;
                        state    <= FAULT;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                SETTLE: begin
                    if (count_done(cnt, SETTLE_CYCLES)) state <= IDLE;
                    else                                cnt   <= sat_inc(cnt);
                end
                FAULT: begin
                    if (fault_clr) begin
                        fault <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (refill) portions_r <= INIT_PORTIONS;
        end
    end

    assign bus.m_ack     = ack_r;
    assign bus.motor_on  = motor_en;
    assign bus.sensor_on = sens_level;
    assign bus.portions  = portions_r;
    assign empty         = (portions_r == '0);
    assign state_dbg     = state;

endmodule

// File: tb/tb_feeder_dispense_ctrl.sv
// Directed bench for feeder_dispense_ctrl: dispense, timeout, empty, glitch,
// refill collision and mid-run reset, with hand-derived expectations.
module tb_feeder_dispense_ctrl;
    import feeder_pkg::*;

    localparam logic [31:0] T_TIMEOUT = 32'd100;
    localparam logic [31:0] T_SETTLE  = 32'd10;
    localparam logic [31:0] T_DEB     = 32'd4;
    localparam logic [2:0]  T_INIT    = 3'd3;
`ifdef FEEDER_DISPENSE_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 2;
`endif

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   sensor_in = 1'b0;
    logic   refill = 1'b0;
    logic   fault_clr = 1'b0;
    logic   motor_en;
    logic   empty;
    logic   fault;
    state_t state_dbg;
    int     n_cmp = 0;
    int     n_err = 0;

    feeder_dispense_ctrl_if bus ();

    always #5 clk = ~clk;

    feeder_dispense_ctrl #(
        .TIMEOUT_CYCLES  (T_TIMEOUT),
        .SETTLE_CYCLES   (T_SETTLE),
        .DEBOUNCE_CYCLES (T_DEB),
        .INIT_PORTIONS   (T_INIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .sensor_in (sensor_in),
        .refill    (refill),
        .fault_clr (fault_clr),
        .motor_en  (motor_en),
        .empty     (empty),
        .fault     (fault),
        .state_dbg (state_dbg)
    );

    task automatic test_reset;
        rst_n = 1'b0;
        bus.m_req = 1'b0;
        #12;
        n_cmp++; if (bus.m_ack !== 1'b0) begin n_err++; $display("FAIL reset_m_ack got %b want 0", bus.m_ack); end
        n_cmp++; if (motor_en !== 1'b0) begin n_err++; $display("FAIL reset_motor_en got %b want 0", motor_en); end
        n_cmp++; if (bus.motor_on !== 1'b0) begin n_err++; $display("FAIL reset_motor_on got %b want 0", bus.motor_on); end
        n_cmp++; if (bus.sensor_on !== 1'b0) begin n_err++; $display("FAIL reset_sensor_on got %b want 0", bus.sensor_on); end
        n_cmp++; if (bus.portions !== 3'd3) begin n_err++; $display("FAIL reset_portions got %0d want 3", bus.portions); end
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL reset_empty got %b want 0", empty); end
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got %b want 0", fault); end
        n_cmp++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL reset_state got %0d want %0d", state_dbg, IDLE); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_normal;
        int acks;
        acks = 0;
        @(negedge clk);
        bus.m_req = 1'b1;
        @(negedge clk);
        acks += int'(bus.m_ack);
        n_cmp++; if (bus.m_ack !== 1'b1) begin n_err++; $display("FAIL normal_ack got %b want 1", bus.m_ack); end
        n_cmp++; if (motor_en !== 1'b1) begin n_err++; $display("FAIL normal_motor_start got %b want 1", motor_en); end
        n_cmp++; if (state_dbg !== RUN) begin n_err++; $display("FAIL normal_state_run got %0d want %0d", state_dbg, RUN); end
        bus.m_req = 1'b0;
        for (int c = 2; c <= 20; c++) begin
            @(negedge clk);
            acks += int'(bus.m_ack);
        end
        n_cmp++; if (motor_en !== 1'b1) begin n_err++; $display("FAIL normal_motor_hold got %b want 1", motor_en); end
        sensor_in = 1'b1;
        for (int i = 1; i <= LAT + 11; i++) begin
            @(negedge clk);
            acks += int'(bus.m_ack);
            if (i == 8) sensor_in = 1'b0;
            if (i == LAT - 1) begin
                n_cmp++; if (bus.sensor_on !== 1'b0) begin n_err++; $display("FAIL normal_sensor_early got %b want 0", bus.sensor_on); end
            end
            if (i == LAT) begin
                n_cmp++; if (bus.sensor_on !== 1'b1) begin n_err++; $display("FAIL normal_sensor_rise got %b want 1", bus.sensor_on); end
                n_cmp++; if (motor_en !== 1'b1) begin n_err++; $display("FAIL normal_motor_before_stop got %b want 1", motor_en); end
            end
            if (i == LAT + 1) begin
                n_cmp++; if (motor_en !== 1'b0) begin n_err++; $display("FAIL normal_motor_stop got %b want 0", motor_en); end
                n_cmp++; if (bus.portions !== 3'd2) begin n_err++; $display("FAIL normal_portions got %0d want 2", bus.portions); end
                n_cmp++; if (state_dbg !== SETTLE) begin n_err++; $display("FAIL normal_state_settle got %0d want %0d", state_dbg, SETTLE); end
            end
            if (i == LAT + 10) begin
                n_cmp++; if (state_dbg !== SETTLE) begin n_err++; $display("FAIL normal_settle_hold got %0d want %0d", state_dbg, SETTLE); end
            end
            if (i == LAT + 11) begin
                n_cmp++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL normal_settle_done got %0d want %0d", state_dbg, IDLE); end
            end
        end
        n_cmp++; if (acks !== 1) begin n_err++; $display("FAIL normal_ack_count got %0d want 1", acks); end
    endtask

    task automatic test_timeout;
        int hi;
        int acks;
        @(negedge clk);
        bus.m_req = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.m_ack !== 1'b1) begin n_err++; $display("FAIL timeout_ack got %b want 1", bus.m_ack); end
        bus.m_req = 1'b0;
        hi = 0;
        for (int k = 0; k < 200; k++) begin
            if (motor_en !== 1'b1) break;
            hi++;
            @(negedge clk);
        end
        n_cmp++; if (hi !== 100) begin n_err++; $display("FAIL timeout_motor_cycles got %0d want 100", hi); end
        n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL timeout_fault got %b want 1", fault); end
        n_cmp++; if (state_dbg !== FAULT) begin n_err++; $display("FAIL timeout_state got %0d want %0d", state_dbg, FAULT); end
        n_cmp++; if (bus.portions !== 3'd2) begin n_err++; $display("FAIL timeout_portions got %0d want 2", bus.portions); end
        bus.m_req = 1'b1;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            acks += int'(bus.m_ack);
        end
        bus.m_req = 1'b0;
        n_cmp++; if (acks !== 0) begin n_err++; $display("FAIL timeout_req_in_fault acks got %0d want 0", acks); end
        n_cmp++; if (state_dbg !== FAULT) begin n_err++; $display("FAIL timeout_state_hold got %0d want %0d", state_dbg, FAULT); end
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL timeout_fault_clr got %b want 0", fault); end
        n_cmp++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL timeout_clr_state got %0d want %0d", state_dbg, IDLE); end
    endtask

    task automatic run_dispense(output bit ok);
        bit got;
        ok = 1'b1;
        got = 1'b0;
        @(negedge clk);
        bus.m_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.m_ack === 1'b1) begin got = 1'b1; break; end
        end
        bus.m_req = 1'b0;
        ok = ok & got;
        repeat (3) @(negedge clk);
        sensor_in = 1'b1;
        repeat (8) @(negedge clk);
        sensor_in = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (state_dbg === IDLE) begin got = 1'b1; break; end
        end
        ok = ok & got;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_empty;
        bit ok;
        @(negedge clk);
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        n_cmp++; if (bus.portions !== 3'd3) begin n_err++; $display("FAIL empty_refill got %0d want 3", bus.portions); end
        for (int d = 0; d < 3; d++) begin
            run_dispense(ok);
            n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL empty_dispense_%0d handshake got %b want 1", d, ok); end
            n_cmp++; if (bus.portions !== 3'(2 - d)) begin n_err++; $display("FAIL empty_portions_%0d got %0d want %0d", d, bus.portions, 2 - d); end
        end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL empty_flag got %b want 1", empty); end
        @(negedge clk);
        bus.m_req = 1'b1;
        @(negedge clk);
        bus.m_req = 1'b0;
        n_cmp++; if (bus.m_ack !== 1'b1) begin n_err++; $display("FAIL empty_ack got %b want 1", bus.m_ack); end
        n_cmp++; if (motor_en !== 1'b0) begin n_err++; $display("FAIL empty_motor got %b want 0", motor_en); end
        n_cmp++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL empty_state got %0d want %0d", state_dbg, IDLE); end
        @(negedge clk);
        n_cmp++; if (bus.m_ack !== 1'b0) begin n_err++; $display("FAIL empty_ack_drop got %b want 0", bus.m_ack); end
        n_cmp++; if (motor_en !== 1'b0) begin n_err++; $display("FAIL empty_motor_after got %b want 0", motor_en); end
    endtask

    task automatic test_glitch;
        logic       seen;
        logic       exp_seen;
        logic [2:0] exp_port;
        bit         got;
        @(negedge clk);
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        bus.m_req = 1'b1;
        @(negedge clk);
        bus.m_req = 1'b0;
        n_cmp++; if (motor_en !== 1'b1) begin n_err++; $display("FAIL glitch_motor_start got %b want 1", motor_en); end
        repeat (3) @(negedge clk);
        seen = 1'b0;
        sensor_in = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            if (i == 3) sensor_in = 1'b0;
            seen = seen | bus.sensor_on;
        end
`ifdef FEEDER_DISPENSE_DEBOUNCE_EN
        exp_seen = 1'b0;
        exp_port = 3'd3;
`else
        exp_seen = 1'b1;
        exp_port = 3'd2;
`endif
        n_cmp++; if (seen !== exp_seen) begin n_err++; $display("FAIL glitch_sensor_on got %b want %b", seen, exp_seen); end
        n_cmp++; if (bus.portions !== exp_port) begin n_err++; $display("FAIL glitch_portions got %0d want %0d", bus.portions, exp_port); end
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (state_dbg === FAULT) begin
                fault_clr = 1'b1;
                @(negedge clk);
                fault_clr = 1'b0;
            end
            if (state_dbg === IDLE) begin got = 1'b1; break; end
        end
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL glitch_return_idle got %b want 1", got); end
    endtask

    task automatic test_refill_collision;
        bit got;
        @(negedge clk);
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        bus.m_req = 1'b1;
        @(negedge clk);
        bus.m_req = 1'b0;
        repeat (3) @(negedge clk);
        sensor_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == LAT) refill = 1'b1;
            if (i == LAT + 1) begin
                refill = 1'b0;
                n_cmp++; if (bus.portions !== 3'd3) begin n_err++; $display("FAIL collision_portions got %0d want 3", bus.portions); end
                n_cmp++; if (motor_en !== 1'b0) begin n_err++; $display("FAIL collision_motor got %b want 0", motor_en); end
                n_cmp++; if (state_dbg !== SETTLE) begin n_err++; $display("FAIL collision_state got %0d want %0d", state_dbg, SETTLE); end
            end
            if (i == 8) sensor_in = 1'b0;
        end
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (state_dbg === IDLE) begin got = 1'b1; break; end
        end
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL collision_return_idle got %b want 1", got); end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        @(negedge clk);
        bus.m_req = 1'b1;
        @(negedge clk);
        bus.m_req = 1'b0;
        n_cmp++; if (motor_en !== 1'b1) begin n_err++; $display("FAIL midrun_motor_before got %b want 1", motor_en); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (motor_en !== 1'b0) begin n_err++; $display("FAIL midrun_motor_en got %b want 0", motor_en); end
        n_cmp++; if (bus.motor_on !== 1'b0) begin n_err++; $display("FAIL midrun_motor_on got %b want 0", bus.motor_on); end
        n_cmp++; if (bus.m_ack !== 1'b0) begin n_err++; $display("FAIL midrun_m_ack got %b want 0", bus.m_ack); end
        n_cmp++; if (bus.sensor_on !== 1'b0) begin n_err++; $display("FAIL midrun_sensor_on got %b want 0", bus.sensor_on); end
        n_cmp++; if (bus.portions !== 3'd3) begin n_err++; $display("FAIL midrun_portions got %0d want 3", bus.portions); end
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL midrun_empty got %b want 0", empty); end
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL midrun_fault got %b want 0", fault); end
        n_cmp++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL midrun_state got %0d want %0d", state_dbg, IDLE); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.m_req = 1'b0;
        test_reset();
        test_normal();
        test_timeout();
        test_empty();
        test_glitch();
        test_refill_collision();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
